// File: rtl/mem_pkg.sv
// Shared definitions for the main memory responder: block geometry, bus
// widths, the responder FSM state encoding and a word-address helper.
package mem_pkg;

    localparam int BLOCK_WORDS = 4;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 32;

    // Beat index width, block-number width (byte address bits above the
    // 16-byte block offset) and word-address width.
    localparam int BEAT_W  = $clog2(BLOCK_WORDS);
    localparam int BLK_W   = ADDR_W - BEAT_W - 2;
    localparam int WORD_AW = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        RD_BEAT = 3'd2,
        WR_BEAT = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Word address of beat 'beat' within block 'blk'.
    function automatic logic [WORD_AW-1:0] word_addr(input logic [BLK_W-1:0]  blk,
                                                     input logic [BEAT_W-1:0] beat);
        return {blk, beat};
    endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Block-transfer bus between a cache-side initiator (master) and the main
// memory responder (slave).
//
// Handshake semantics: a transfer on a channel happens at a rising clock
// edge where both valid and ready are 1. req: valid from master, ready from
// slave. wdata: valid from master, ready from slave (ready is held while the
// slave is collecting write beats). rdata has no ready: the slave streams
// four beats back to back and the master must take them. done is a
// one-cycle pulse from the slave after the last beat of either direction.
//
// Signals: req_valid/req_ready/req_write/req_addr, wdata_valid/wdata_ready/
// wdata, rdata_valid/rdata/rdata_last, done.
interface main_memory_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;

    logic              done;

    modport master (
        output req_valid, req_write, req_addr, wdata_valid, wdata,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, wdata_valid, wdata,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done
    );

endinterface

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read.
// Ports: clk, rst_n (clears only the read register, never the array),
// we/re (write/read enables, never both in one cycle), addr (word address),
// wdata (write data), rdata (registered read data, holds when re = 0).
module mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS),
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH_WORDS];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // No reset on the storage so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder: accepts 4-word block refill reads and write-backs
// over main_memory_responder_if, waits LATENCY access cycles, then streams
// or collects the four beats in ascending word order and pulses done.
// Ports: clk, rst_n (async, active low), bus (slave modport),
// dbg_state (current FSM state, for observation only).
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    main_memory_responder_if.slave        bus,
    output state_e                        dbg_state
);

    localparam int              MEM_AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]      LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    state_e             state_q, state_d;
    logic [3:0]         lat_cnt_q, lat_cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic               write_q, write_d;
    logic               req_ready_q, req_ready_d;
    logic               wdata_ready_q, wdata_ready_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               rdata_last_q, rdata_last_d;
    logic               done_q, done_d;

    logic               wr_en;
    logic               rd_en;
    logic [WORD_AW-1:0] wr_word;
    logic [WORD_AW-1:0] rd_word;
    logic [MEM_AW-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rdata;
    logic               addr_unused;

    // Byte offset within a block is ignored.
    assign addr_unused = ^bus.req_addr[ADDR_W-BLK_W-1:0];

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        blk_d     = blk_q;
        write_d   = write_q;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                // req_ready is 1 exactly in IDLE, so req_valid here is acceptance.
                if (bus.req_valid) begin
                    blk_d   = bus.req_addr[ADDR_W-1 -: BLK_W];
                    write_d = bus.req_write;
                    beat_d  = '0;
                    if (LATENCY == 0) begin
                        state_d = bus.req_write ? WR_BEAT : RD_BEAT;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = write_q ? WR_BEAT : RD_BEAT;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            RD_BEAT: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            WR_BEAT: begin
                if (bus.wdata_valid) begin
                    wr_en = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The RAM read is launched from next-state values so the registered RAM
    // output lines up with the cycle the FSM spends on that beat.
    assign rd_en   = (state_d == RD_BEAT);
    assign rd_word = word_addr(blk_d, beat_d);
    assign wr_word = word_addr(blk_q, beat_q);
    assign mem_addr = MEM_AW'(wr_en ? wr_word : rd_word);

    // Outputs registered from the next state so they coincide with state_q.
    always_comb begin
        req_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WR_BEAT);
        rdata_valid_d = rd_en;
        rdata_last_d  = rd_en && (beat_d == LAST_BEAT);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            beat_q        <= '0;
            blk_q         <= '0;
            write_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            beat_q        <= beat_d;
            blk_q         <= blk_d;
            write_q       <= write_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
            done_q        <= done_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (MEM_AW),
        .DW          (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .re    (rd_en),
        .addr  (mem_addr),
        .wdata (bus.wdata),
        .rdata (mem_rdata)
    );

    assign bus.req_ready   = req_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.rdata       = mem_rdata;
    assign bus.done        = done_q;
    assign dbg_state       = state_q;

endmodule
